// File: rtl/encoder4to2_pkg.sv
// Shared constants and helpers for the debounced 4-to-2 priority encoder.
package encoder4to2_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DEBOUNCE = 2'b01,
      VALID    = 2'b10,
      RELEASE  = 2'b11
   } state_t;

   localparam logic [1:0] CODE_LINE0 = 2'b00;
   localparam logic [1:0] CODE_LINE1 = 2'b01;
   localparam logic [1:0] CODE_LINE2 = 2'b10;
   localparam logic [1:0] CODE_LINE3 = 2'b11;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // Highest-numbered active line wins.
   function automatic logic [1:0] encode(input logic [3:0] v);
      if (v[3])      return CODE_LINE3;
      else if (v[2]) return CODE_LINE2;
      else if (v[1]) return CODE_LINE1;
      else           return CODE_LINE0;
   endfunction

   // Clearing the lowest set bit leaves something only if two or more were set.
   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/synchronizer_2stage.sv
// Two-flop synchroniser for asynchronous request lines.
module synchronizer_2stage #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/encoder4to2_debounced_handshake.sv
// Synchronises and debounces four request lines, priority-encodes the
// captured snapshot and offers the code through a valid/acknowledge handshake.
module encoder4to2_debounced_handshake
   import encoder4to2_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int COUNT_WIDTH     = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic input0,
   input  logic input1,
   input  logic input2,
   input  logic input3,
   input  logic acknowledge,
   output logic output0,
   output logic output1,
   output logic valid,
   output logic multiple
);

   localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [3:0]             s;
   state_t                 state, state_next;
   logic [3:0]             snapshot, snap_next;
   logic [COUNT_WIDTH-1:0] count, count_next;
   logic [1:0]             code, code_next;
   logic                   multi, multi_next;

   synchronizer_2stage #(.WIDTH(4)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     ({input3, input2, input1, input0}),
      .q     (s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         snapshot <= '0;
         count    <= '0;
         code     <= '0;
         multi    <= 1'b0;
      end else begin
         state    <= state_next;
         snapshot <= snap_next;
         count    <= count_next;
         code     <= code_next;
         multi    <= multi_next;
      end
   end

   always_comb begin
      state_next = state;
      snap_next  = snapshot;
      count_next = count;
      code_next  = code;
      multi_next = multi;
      case (state)
         IDLE: begin
            if (enable && s != 4'd0) begin
               snap_next  = s;
               count_next = '0;
               state_next = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            // Any movement of the synchronised vector restarts the stability window.
            if (!enable || s == 4'd0) begin
               state_next = IDLE;
            end else if (s != snapshot) begin
               snap_next  = s;
               count_next = '0;
            end else if (count == LAST) begin
               code_next  = encode(snapshot);
               multi_next = multi_hot(snapshot);
               state_next = VALID;
            end else begin
               count_next = count + 1'b1;
            end
         end
         VALID: begin
            if (acknowledge) state_next = RELEASE;
         end
         RELEASE: begin
            // Wait for full release so one press yields one capture.
            if (s == 4'd0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign valid    = (state == VALID);
   assign output0  = code[0];
   assign output1  = code[1];
   assign multiple = multi;

endmodule

// File: tb/tb_encoder4to2_debounced_handshake.sv
// Directed bench for the debounced 4-to-2 encoder handshake.
module tb_encoder4to2_debounced_handshake;

   logic clock = 1'b0;
   logic reset, enable, acknowledge;
   logic input0, input1, input2, input3;
   logic output0, output1, valid, multiple;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses;

   encoder4to2_debounced_handshake #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .input0      (input0),
      .input1      (input1),
      .input2      (input2),
      .input3      (input3),
      .acknowledge (acknowledge),
      .output0     (output0),
      .output1     (output1),
      .valid       (valid),
      .multiple    (multiple)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // valid must stay low for n-1 edges and be high right after edge n.
   task automatic expect_valid_after(input int n, input string tag);
      for (int i = 1; i < n; i++) begin
         tick(1);
         check({tag, "_early"}, {7'd0, valid}, 8'd0);
      end
      tick(1);
      check({tag, "_valid"}, {7'd0, valid}, 8'd1);
   endtask

   task automatic ack_and_clear();
      acknowledge = 1'b1;
      tick(1);
      check("ack_drops_valid", {7'd0, valid}, 8'd0);
      acknowledge = 1'b0;
      {input3, input2, input1, input0} = 4'b0000;
      tick(4);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; acknowledge = 1'b0;
      {input3, input2, input1, input0} = 4'b0000;
      tick(2);
      check("reset_valid", {7'd0, valid}, 8'd0);
      check("reset_code", {6'd0, output1, output0}, 8'd0);
      check("reset_multiple", {7'd0, multiple}, 8'd0);
      reset = 1'b0;
      tick(1);

      // Capture line2, then hit reset between edges while it is still held.
      input2 = 1'b1;
      expect_valid_after(7, "pre_reset");
      check("pre_reset_code", {6'd0, output1, output0}, 8'h2);
      #2 reset = 1'b1;
      #1;
      check("async_reset_valid", {7'd0, valid}, 8'd0);
      check("async_reset_code", {6'd0, output1, output0}, 8'd0);
      input2 = 1'b0;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_no_valid", {7'd0, valid}, 8'd0);
      end

      // Single press at default latency.
      input2 = 1'b1;
      expect_valid_after(7, "press2");
      check("press2_code", {6'd0, output1, output0}, 8'h2);
      check("press2_multiple", {7'd0, multiple}, 8'd0);
      acknowledge = 1'b1;
      tick(1);
      check("press2_ack", {7'd0, valid}, 8'd0);
      acknowledge = 1'b0;
      tick(3);
      check("release_held", {7'd0, valid}, 8'd0);
      input2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("after_release", {7'd0, valid}, 8'd0);
      end

      // Bounce on line1: count measured from the final rising toggle.
      input1 = 1'b1; tick(1);
      input1 = 1'b0; tick(1);
      input1 = 1'b1;
      expect_valid_after(7, "bounce");
      check("bounce_code", {6'd0, output1, output0}, 8'h1);
      ack_and_clear();

      // Priority and multiple detection.
      input0 = 1'b1; input3 = 1'b1;
      expect_valid_after(7, "multi");
      check("multi_code", {6'd0, output1, output0}, 8'h3);
      check("multi_flag", {7'd0, multiple}, 8'd1);
      ack_and_clear();
      input1 = 1'b1;
      expect_valid_after(7, "single1");
      check("single1_code", {6'd0, output1, output0}, 8'h1);
      check("single1_multiple", {7'd0, multiple}, 8'd0);
      ack_and_clear();

      // Handshake holds through input change and enable drop.
      input2 = 1'b1;
      expect_valid_after(7, "hold");
      input2 = 1'b0; input0 = 1'b1; enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check("hold_valid", {7'd0, valid}, 8'd1);
         check("hold_code", {6'd0, output1, output0}, 8'h2);
      end
      acknowledge = 1'b1;
      tick(1);
      check("hold_ack", {7'd0, valid}, 8'd0);
      input0 = 1'b0; enable = 1'b1;
      tick(4);

      // Acknowledge tied high: exactly one valid cycle per capture.
      input3 = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (valid === 1'b1) pulses++;
      end
      check("ack_high_pulses", 8'(pulses), 8'd1);
      check("ack_high_code_kept", {6'd0, output1, output0}, 8'h3);
      input3 = 1'b0; acknowledge = 1'b0;
      tick(4);

      // Enable gating, then release the gate with the line still held.
      enable = 1'b0; input1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("gated_no_valid", {7'd0, valid}, 8'd0);
      end
      enable = 1'b1;
      expect_valid_after(5, "enable_on");
      check("enable_on_code", {6'd0, output1, output0}, 8'h1);
      ack_and_clear();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
